// File: rtl/parity_serial_tx.sv
// Serial transmitter with odd parity: start bit, N data bits LSB first, parity bit, stop bit.
// Each bit is held for CLKS_PER_BIT cycles. A valid/ready handshake is accepted only while idle.
module parity_serial_tx #(
   parameter int N            = 5,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] data_in,
   input  logic         data_valid,
   output logic         data_ready,
   output logic         tx_serial,
   output logic         tx_busy,
   output logic         done
);

   localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
   localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [BIT_W-1:0] r_bitCnt;
   logic [CYC_W-1:0] r_cycCnt;
   logic [N-1:0]     r_shift;
   logic             r_parity;
   logic             r_readyEn;
   logic             w_accept;
   logic             w_cycLast;
   logic             w_bitLast;

   // r_readyEn holds data_ready low for the first cycle coming out of reset.
   assign w_accept  = (r_state == IDLE) && r_readyEn && data_valid;
   assign w_cycLast = (r_cycCnt == CYC_LAST);
   assign w_bitLast = (r_bitCnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_bitCnt  <= '0;
         r_cycCnt  <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_readyEn <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_readyEn <= 1'b1;
         if (w_accept) begin
            r_shift  <= data_in;
            r_parity <= ~^data_in;
         end
         if (r_state == IDLE) begin
            r_cycCnt <= '0;
            r_bitCnt <= '0;
         end else if (w_cycLast) begin
            r_cycCnt <= '0;
            if (r_state == DATA) begin
               r_shift  <= r_shift >> 1;
               r_bitCnt <= w_bitLast ? '0 : r_bitCnt + 1'b1;
            end
         end else begin
            r_cycCnt <= r_cycCnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      data_ready  = 1'b0;
      tx_serial   = 1'b1;
      tx_busy     = 1'b1;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            tx_busy    = 1'b0;
            data_ready = r_readyEn;
            if (w_accept) w_nextState = START;
         end
         START: begin
            tx_serial = 1'b0;
            if (w_cycLast) w_nextState = DATA;
         end
         DATA: begin
            tx_serial = r_shift[0];
            if (w_cycLast && w_bitLast) w_nextState = PARITY;
         end
         PARITY: begin
            tx_serial = r_parity;
            if (w_cycLast) w_nextState = STOP;
         end
         STOP: begin
            done = w_cycLast;
            if (w_cycLast) w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: a CLKS_PER_BIT=4 instance and a CLKS_PER_BIT=1 instance
// share clock and reset; expected frames are hand-computed bit lists (bit 0 = start .. bit 7 = stop).
module tb_parity_serial_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] dataIn;
   logic       dataValid;
   logic       dataReady;
   logic       txSerial;
   logic       txBusy;
   logic       doneP;
   logic [4:0] dataInF;
   logic       dataValidF;
   logic       dataReadyF;
   logic       txSerialF;
   logic       txBusyF;
   logic       doneF;

   int errors = 0;
   int checks = 0;

   parity_serial_tx #(.N(5), .CLKS_PER_BIT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (dataIn),
      .data_valid (dataValid),
      .data_ready (dataReady),
      .tx_serial  (txSerial),
      .tx_busy    (txBusy),
      .done       (doneP)
   );

   parity_serial_tx #(.N(5), .CLKS_PER_BIT(1)) dutFast (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (dataInF),
      .data_valid (dataValidF),
      .data_ready (dataReadyF),
      .tx_serial  (txSerialF),
      .tx_busy    (txBusyF),
      .done       (doneF)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
   task automatic startWord(input bit fast, input logic [4:0] w);
      @(posedge clk);
      #1;
      if (fast) begin dataInF = w; dataValidF = 1'b1; end
      else begin dataIn = w; dataValid = 1'b1; end
      @(posedge clk);
      #1;
      if (fast) dataValidF = 1'b0;
      else dataValid = 1'b0;
   endtask

   // Records one frame starting on the cycle after the accept edge; makes no comparisons itself.
   task automatic watchFrame(input bit fast, input int clks, output logic [7:0] bits,
                             output bit steady, output bit busyHigh,
                             output int doneAt, output int doneCount);
      logic tx;
      int   k;
      bits = '0; steady = 1'b1; busyHigh = 1'b1; doneAt = 0; doneCount = 0;
      for (int c = 0; c < 8 * clks; c++) begin
         @(negedge clk);
         tx = fast ? txSerialF : txSerial;
         k  = c / clks;
         if (c % clks == 0) bits[k] = tx;
         else if (tx !== bits[k]) steady = 1'b0;
         if ((fast ? txBusyF : txBusy) !== 1'b1) busyHigh = 1'b0;
         if ((fast ? doneF : doneP) === 1'b1) begin
            doneCount++;
            if (doneAt == 0) doneAt = c + 1;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; dataIn = 5'd3; dataValid = 1'b1; dataInF = 5'd0; dataValidF = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (txSerial !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", txSerial); end
      checks++; if (txBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", txBusy); end
      checks++; if (doneP !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", doneP); end
      checks++; if (dataReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", dataReady); end
      checks++; if (txSerialF !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_fast: got %b expected 1", txSerialF); end
      @(posedge clk);
      #1 rst_n = 1'b1; dataValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (dataReady !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", dataReady); end
      checks++; if (dataReadyF !== 1'b1) begin errors++; $display("[TB] FAIL release_ready_fast: got %b expected 1", dataReadyF); end
      checks++; if (txBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_word_accepted: busy got %b expected 0", txBusy); end
   endtask

   task automatic test_single_frame;
      logic [7:0] bits; bit steady; bit busyHigh; int doneAt; int doneCount;
      startWord(1'b0, 5'd3);
      watchFrame(1'b0, 4, bits, steady, busyHigh, doneAt, doneCount);
      checks++; if (bits !== 8'hC6) begin errors++; $display("[TB] FAIL word3_bits: got %h expected c6", bits); end
      checks++; if (steady !== 1'b1) begin errors++; $display("[TB] FAIL word3_bit_hold: got %b expected 1", steady); end
      checks++; if (busyHigh !== 1'b1) begin errors++; $display("[TB] FAIL word3_busy: got %b expected 1", busyHigh); end
      checks++; if (doneAt !== 32) begin errors++; $display("[TB] FAIL word3_done_cycle: got %0d expected 32", doneAt); end
      checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL word3_done_count: got %0d expected 1", doneCount); end
      @(negedge clk);
      checks++; if (dataReady !== 1'b1) begin errors++; $display("[TB] FAIL word3_ready_after: got %b expected 1", dataReady); end
      checks++; if (txBusy !== 1'b0) begin errors++; $display("[TB] FAIL word3_busy_after: got %b expected 0", txBusy); end
   endtask

   task automatic test_back_to_back;
      logic [4:0] words [4] = '{5'd9, 5'd7, 5'd17, 5'd19};
      logic [7:0] expBits [4] = '{8'hD2, 8'h8E, 8'hE2, 8'hA6};
      logic [7:0] bits; bit steady; bit busyHigh; int doneAt; int doneCount;
      @(posedge clk);
      #1 dataIn = words[0]; dataValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 if (i < 3) dataIn = words[i + 1];
         watchFrame(1'b0, 4, bits, steady, busyHigh, doneAt, doneCount);
         checks++; if (bits !== expBits[i]) begin errors++; $display("[TB] FAIL b2b_bits[%0d]: got %h expected %h", i, bits, expBits[i]); end
         checks++; if (doneAt !== 32) begin errors++; $display("[TB] FAIL b2b_done_cycle[%0d]: got %0d expected 32", i, doneAt); end
         @(negedge clk);
         checks++; if ({txSerial, txBusy, dataReady} !== 3'b101) begin
            errors++; $display("[TB] FAIL b2b_idle_gap[%0d]: tx/busy/ready got %b expected 101", i, {txSerial, txBusy, dataReady});
         end
         if (i == 3) dataValid = 1'b0;
      end
      @(negedge clk);
      checks++; if (txBusy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_extra: busy got %b expected 0", txBusy); end
   endtask

   task automatic test_parity_extremes;
      logic [4:0] words [2] = '{5'd0, 5'd31};
      logic [7:0] expBits [2] = '{8'hC0, 8'hBE};
      logic [7:0] bits; bit steady; bit busyHigh; int doneAt; int doneCount;
      for (int i = 0; i < 2; i++) begin
         startWord(1'b0, words[i]);
         watchFrame(1'b0, 4, bits, steady, busyHigh, doneAt, doneCount);
         checks++; if (bits !== expBits[i]) begin errors++; $display("[TB] FAIL extreme_bits[%0d]: got %h expected %h", i, bits, expBits[i]); end
         checks++; if (($countones(bits[6:1]) % 2) != 1) begin
            errors++; $display("[TB] FAIL extreme_odd_ones[%0d]: data+parity ones got %0d expected odd", i, $countones(bits[6:1]));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_mid_frame;
      logic [7:0] bits; bit steady; bit busyHigh; int doneAt; int doneCount;
      int busySeen;
      startWord(1'b0, 5'd9);
      fork
         watchFrame(1'b0, 4, bits, steady, busyHigh, doneAt, doneCount);
         begin
            repeat (10) @(posedge clk);
            #1 dataIn = 5'd22; dataValid = 1'b1;
            @(posedge clk);
            #1 dataValid = 1'b0;
         end
      join
      checks++; if (bits !== 8'hD2) begin errors++; $display("[TB] FAIL midframe_bits: got %h expected d2", bits); end
      checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL midframe_done_count: got %0d expected 1", doneCount); end
      busySeen = 0;
      repeat (8) begin
         @(negedge clk);
         if (txBusy === 1'b1) busySeen++;
      end
      checks++; if (busySeen !== 0) begin errors++; $display("[TB] FAIL midframe_extra_frame: busy cycles got %0d expected 0", busySeen); end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] bits; bit steady; bit busyHigh; int doneAt; int doneCount;
      int doneSeen;
      int busySeen;
      doneSeen = 0;
      startWord(1'b0, 5'd9);
      repeat (25) begin
         @(negedge clk);
         if (doneP === 1'b1) doneSeen++;
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++; if (txBusy !== 1'b1) begin errors++; $display("[TB] FAIL parity_busy_before_reset: got %b expected 1", txBusy); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({txSerial, txBusy, doneP} !== 3'b100) begin
         errors++; $display("[TB] FAIL midreset_outputs: tx/busy/done got %b expected 100", {txSerial, txBusy, doneP});
      end
      busySeen = 0;
      repeat (8) begin
         @(negedge clk);
         if (doneP === 1'b1) doneSeen++;
         if (txBusy === 1'b1) busySeen++;
      end
      checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL midreset_done: pulses got %0d expected 0", doneSeen); end
      checks++; if (busySeen !== 0) begin errors++; $display("[TB] FAIL midreset_resume: busy cycles got %0d expected 0", busySeen); end
      startWord(1'b0, 5'd7);
      watchFrame(1'b0, 4, bits, steady, busyHigh, doneAt, doneCount);
      checks++; if (bits !== 8'h8E) begin errors++; $display("[TB] FAIL postreset_bits: got %h expected 8e", bits); end
      checks++; if (doneAt !== 32) begin errors++; $display("[TB] FAIL postreset_done_cycle: got %0d expected 32", doneAt); end
      @(negedge clk);
   endtask

   task automatic test_one_clk_per_bit;
      logic [7:0] bits; bit steady; bit busyHigh; int doneAt; int doneCount;
      startWord(1'b1, 5'd17);
      watchFrame(1'b1, 1, bits, steady, busyHigh, doneAt, doneCount);
      checks++; if (bits !== 8'hE2) begin errors++; $display("[TB] FAIL fast_bits: got %h expected e2", bits); end
      checks++; if (doneAt !== 8) begin errors++; $display("[TB] FAIL fast_done_cycle: got %0d expected 8", doneAt); end
      checks++; if (busyHigh !== 1'b1) begin errors++; $display("[TB] FAIL fast_busy: got %b expected 1", busyHigh); end
      @(negedge clk);
      checks++; if ({txSerialF, txBusyF, dataReadyF} !== 3'b101) begin
         errors++; $display("[TB] FAIL fast_idle_after: tx/busy/ready got %b expected 101", {txSerialF, txBusyF, dataReadyF});
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_parity_extremes();
      test_ignore_mid_frame();
      test_reset_mid_frame();
      test_one_clk_per_bit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
